// File: rtl/i2c_pkg.sv
// Shared I2C definitions.
// Holds the bus address width and the state types of the I2C target
// (i2c_slave) and of the I2C controller (master), so that both ends of the
// bus agree on encodings when they are viewed together.
package i2c_pkg;

    localparam int unsigned I2C_ADDR_W = 7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_RX,
        S_RX_ACK,
        S_TX,
        S_TX_ACK
    } i2c_slave_state_t;

    typedef enum logic [2:0] {
        M_IDLE,
        M_START,
        M_ADDR,
        M_DATA,
        M_ACK,
        M_STOP
    } i2c_master_state_t;

endpackage

// File: rtl/i2c_sync_edge.sv
// Synchronizer plus edge detector for one asynchronous bus line.
// Ports:
//   i_clk    - system clock
//   i_rst_n  - synchronous active-low reset (flops preset to 1 = idle bus)
//   i_d      - asynchronous line input
//   o_level  - synchronized line level
//   o_rise   - one-cycle pulse on a synchronized 0->1 transition
//   o_fall   - one-cycle pulse on a synchronized 1->0 transition
module i2c_sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync <= '1;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_level = r_sync[STAGES-1];
    assign o_rise  = r_sync[STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/i2c_slave.sv
// I2C target with a single 7-bit address.
// Ports:
//   clk_i, rst_ni  - clock, synchronous active-low reset
//   scl_i, sda_i   - bus lines (asynchronous to clk_i)
//   sda_oe_o       - 1 pulls SDA low, 0 releases it
//   rx_data_o      - last byte written by the master, rx_valid_o pulses on update
//   tx_data_i      - byte returned on a read, captured when tx_load_o pulses
//   rw_o           - R/W bit of the last matched address byte
//   busy_o         - addressed; from match until STOP, START or NACK
//   stop_o         - one-cycle pulse on STOP while busy_o was high
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] OWN_ADDR    = 7'h42,
    parameter int unsigned           SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic [7:0] tx_data_i,
    output logic       tx_load_o,
    output logic       rw_o,
    output logic       busy_o,
    output logic       stop_o
);

    logic w_scl, w_scl_rise, w_scl_fall;
    logic w_sda, w_sda_rise, w_sda_fall;
    logic w_start, w_stop;

    i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_scl_sync (
        .i_clk   (clk_i),
        .i_rst_n (rst_ni),
        .i_d     (scl_i),
        .o_level (w_scl),
        .o_rise  (w_scl_rise),
        .o_fall  (w_scl_fall)
    );

    i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda_sync (
        .i_clk   (clk_i),
        .i_rst_n (rst_ni),
        .i_d     (sda_i),
        .o_level (w_sda),
        .o_rise  (w_sda_rise),
        .o_fall  (w_sda_fall)
    );

    assign w_start = w_sda_fall & w_scl;
    assign w_stop  = w_sda_rise & w_scl;

    i2c_slave_state_t r_state;
    logic [2:0]       r_cnt;
    logic [6:0]       r_rx_shift;   // first seven bits of the byte in flight
    logic [6:0]       r_tx_shift;   // bits still to send, next one at [6]
    logic             r_sda_oe;
    logic [7:0]       r_rx_data;
    logic             r_rx_valid;
    logic             r_tx_load;
    logic             r_rw;
    logic             r_busy;
    logic             r_stop;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_rx_shift <= '0;
            r_tx_shift <= '0;
            r_sda_oe   <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_tx_load  <= 1'b0;
            r_rw       <= 1'b0;
            r_busy     <= 1'b0;
            r_stop     <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_tx_load  <= 1'b0;
            r_stop     <= 1'b0;
            if (w_start) begin
                r_state  <= S_ADDR;
                r_cnt    <= '0;
                r_sda_oe <= 1'b0;
                r_busy   <= 1'b0;
            end else if (w_stop) begin
                r_state  <= S_IDLE;
                r_sda_oe <= 1'b0;
                r_stop   <= r_busy;
                r_busy   <= 1'b0;
            end else begin
                unique case (r_state)
                    S_IDLE: ;
                    S_ADDR: begin
                        if (w_scl_rise) begin
                            r_rx_shift <= {r_rx_shift[5:0], w_sda};
                            r_cnt      <= r_cnt + 3'd1;
                            if (r_cnt == 3'd7) begin
                                if (r_rx_shift == OWN_ADDR) begin
                                    r_rw    <= w_sda;
                                    r_busy  <= 1'b1;
                                    r_state <= S_ADDR_ACK;
                                end else begin
                                    r_state <= S_IDLE;
                                end
                            end
                        end
                    end
                    // Both ACK states span two SCL falls: the first one
                    // starts driving the ACK, the second one ends it.
                    // sda_oe itself tells which of the two falls this is.
                    S_ADDR_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_sda_oe) begin
                                r_sda_oe <= 1'b1;
                            end else if (!r_rw) begin
                                r_sda_oe <= 1'b0;
                                r_cnt    <= '0;
                                r_state  <= S_RX;
                            end else begin
                                r_tx_shift <= tx_data_i[6:0];
                                r_tx_load  <= 1'b1;
                                r_sda_oe   <= ~tx_data_i[7];
                                r_cnt      <= '0;
                                r_state    <= S_TX;
                            end
                        end
                    end
                    S_RX: begin
                        if (w_scl_rise) begin
                            r_rx_shift <= {r_rx_shift[5:0], w_sda};
                            r_cnt      <= r_cnt + 3'd1;
                            if (r_cnt == 3'd7) begin
                                r_rx_data  <= {r_rx_shift, w_sda};
                                r_rx_valid <= 1'b1;
                                r_state    <= S_RX_ACK;
                            end
                        end
                    end
                    S_RX_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_sda_oe) begin
                                r_sda_oe <= 1'b1;
                            end else begin
                                r_sda_oe <= 1'b0;
                                r_state  <= S_RX;
                            end
                        end
                    end
                    // Counter wraps to 0 on the 8th rise, so the fall that
                    // follows with r_cnt == 0 ends the byte.
                    S_TX: begin
                        if (w_scl_rise) begin
                            r_cnt <= r_cnt + 3'd1;
                        end else if (w_scl_fall) begin
                            if (r_cnt == 3'd0) begin
                                r_sda_oe <= 1'b0;
                                r_state  <= S_TX_ACK;
                            end else begin
                                r_sda_oe   <= ~r_tx_shift[6];
                                r_tx_shift <= {r_tx_shift[5:0], 1'b0};
                            end
                        end
                    end
                    // A NACK leaves on the rise, so any fall seen here
                    // follows a master ACK.
                    S_TX_ACK: begin
                        if (w_scl_rise && w_sda) begin
                            r_sda_oe <= 1'b0;
                            r_busy   <= 1'b0;
                            r_state  <= S_IDLE;
                        end else if (w_scl_fall) begin
                            r_tx_shift <= tx_data_i[6:0];
                            r_tx_load  <= 1'b1;
                            r_sda_oe   <= ~tx_data_i[7];
                            r_cnt      <= '0;
                            r_state    <= S_TX;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign sda_oe_o   = r_sda_oe;
    assign rx_data_o  = r_rx_data;
    assign rx_valid_o = r_rx_valid;
    assign tx_load_o  = r_tx_load;
    assign rw_o       = r_rw;
    assign busy_o     = r_busy;
    assign stop_o     = r_stop;

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a bit-level bus master drives transfers,
// a transaction model predicts ACKs, written bytes and read bytes, and a
// per-cycle monitor checks the target's outputs against that model.
module tb_i2c_slave;

    localparam int          Q   = 6;        // clk cycles per quarter SCL period
    localparam logic [6:0]  OWN = 7'h42;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       m_scl, m_sda;
    logic       w_sda_bus;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       rw;
    logic       busy;
    logic       stop_p;

    always #5 clk = ~clk;

    // open-drain bus: either side may pull SDA low
    assign w_sda_bus = m_sda & ~sda_oe;

    i2c_slave #(.OWN_ADDR(OWN), .SYNC_STAGES(2)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .scl_i      (m_scl),
        .sda_i      (w_sda_bus),
        .sda_oe_o   (sda_oe),
        .rx_data_o  (rx_data),
        .rx_valid_o (rx_valid),
        .tx_data_i  (tx_data),
        .tx_load_o  (tx_load),
        .rw_o       (rw),
        .busy_o     (busy),
        .stop_o     (stop_p)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_rx     = 0;
    int n_txl    = 0;
    int n_stop   = 0;
    bit m_quiet  = 1'b1;          // model: target must not drive SDA now
    logic [7:0] rx_exp[$];        // model: bytes the target must report
    logic [7:0] tx_src[$];        // bytes offered on tx_data_i, in order

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // model: does the target answer this address byte
    function automatic bit addressed(input logic [7:0] a);
        return a[7:1] == OWN;
    endfunction

    // compare process
    always @(negedge clk) begin
        if (m_quiet) check("sda_quiet", {31'b0, sda_oe}, 32'h0);
        if (rx_valid) begin
            n_rx++;
            if (rx_exp.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rx_valid: got pulse with data 0x%0h, none expected", rx_data);
            end else begin
                check("rx_data", {24'b0, rx_data}, {24'b0, rx_exp.pop_front()});
            end
        end
        if (tx_load) begin
            n_txl++;
            if (tx_src.size() > 0) void'(tx_src.pop_front());
        end
        if (stop_p) n_stop++;
        tx_data = (tx_src.size() > 0) ? tx_src[0] : 8'hEE;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic qw();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_start();
        m_sda = 1'b1; qw();
        m_scl = 1'b1; qw();
        m_sda = 1'b0; qw();
        m_scl = 1'b0; qw();
        m_quiet = 1'b1;
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; qw();
        m_scl = 1'b1; qw();
        m_sda = 1'b1; qw();
        m_quiet = 1'b1;
    endtask

    // one SCL clock; s is the bus level seen while SCL is high
    task automatic bus_bit(input logic b, output logic s);
        m_sda = b;    qw();
        m_scl = 1'b1; qw();
        s = w_sda_bus; qw();
        m_scl = 1'b0; qw();
    endtask

    // opens the model for target drive right before the 8th bit when the
    // address is ours, since the ACK is asserted at that bit's falling edge
    task automatic write_byte(input logic [7:0] b, input bit open_after, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            if (i == 0 && open_after) m_quiet = 1'b0;
            bus_bit(b[i], s);
        end
        bus_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input bit mack, output logic [7:0] d);
        logic s;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            bus_bit(1'b1, s);
            d = {d[6:0], s};
        end
        bus_bit(~mack, s);
        if (!mack) m_quiet = 1'b1;
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        logic       s;
        int r0, t0, s0;

        rst_n = 1'b0; m_scl = 1'b1; m_sda = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_sda_oe",   {31'b0, sda_oe},   0);
        check("rst_rx_data",  {24'b0, rx_data},  0);
        check("rst_rx_valid", {31'b0, rx_valid}, 0);
        check("rst_tx_load",  {31'b0, tx_load},  0);
        check("rst_busy",     {31'b0, busy},     0);
        check("rst_stop",     {31'b0, stop_p},   0);
        check("rst_rw",       {31'b0, rw},       0);
        rst_n = 1'b1;
        qw();

        // write 0x84, 0xA5, STOP
        r0 = n_rx; s0 = n_stop;
        bus_start();
        write_byte(8'h84, addressed(8'h84), ack);
        check("wr_addr_ack", {31'b0, ack}, 1);
        check("wr_busy", {31'b0, busy}, 1);
        rx_exp.push_back(8'hA5);
        write_byte(8'hA5, 1'b0, ack);
        check("wr_data_ack", {31'b0, ack}, 1);
        check("wr_rx_data", {24'b0, rx_data}, 32'hA5);
        check("wr_rw", {31'b0, rw}, 0);
        bus_stop(); qw();
        check("wr_rx_pulses", n_rx - r0, 1);
        check("wr_stop_pulses", n_stop - s0, 1);
        check("wr_busy_after_stop", {31'b0, busy}, 0);

        // read 0x85: 0x3C (ACK), 0xF0 (NACK)
        tx_src.push_back(8'h3C); tx_src.push_back(8'hF0);
        t0 = n_txl; s0 = n_stop;
        bus_start();
        write_byte(8'h85, addressed(8'h85), ack);
        check("rd_addr_ack", {31'b0, ack}, 1);
        check("rd_rw", {31'b0, rw}, 1);
        read_byte(1'b1, d);
        check("rd_byte0", {24'b0, d}, 32'h3C);
        read_byte(1'b0, d);
        check("rd_byte1", {24'b0, d}, 32'hF0);
        check("rd_busy_after_nack", {31'b0, busy}, 0);
        check("rd_tx_loads", n_txl - t0, 2);
        bus_stop(); qw();
        check("rd_stop_pulses", n_stop - s0, 0);

        // address mismatch 0x90, 0x11
        r0 = n_rx; s0 = n_stop;
        bus_start();
        write_byte(8'h90, addressed(8'h90), ack);
        check("mm_addr_ack", {31'b0, ack}, 0);
        write_byte(8'h11, 1'b0, ack);
        check("mm_data_ack", {31'b0, ack}, 0);
        check("mm_busy", {31'b0, busy}, 0);
        bus_stop(); qw();
        check("mm_rx_pulses", n_rx - r0, 0);
        check("mm_stop_pulses", n_stop - s0, 0);

        // write 0x84, 0x01, Sr, read 0x85 one byte, NACK, STOP
        tx_src.push_back(8'h77);
        s0 = n_stop;
        bus_start();
        write_byte(8'h84, addressed(8'h84), ack);
        check("sr_waddr_ack", {31'b0, ack}, 1);
        rx_exp.push_back(8'h01);
        write_byte(8'h01, 1'b0, ack);
        check("sr_wdata_ack", {31'b0, ack}, 1);
        bus_start();
        check("sr_busy_after_sr", {31'b0, busy}, 0);
        write_byte(8'h85, addressed(8'h85), ack);
        check("sr_raddr_ack", {31'b0, ack}, 1);
        check("sr_rw", {31'b0, rw}, 1);
        read_byte(1'b0, d);
        check("sr_rbyte", {24'b0, d}, 32'h77);
        bus_stop(); qw();
        check("sr_rx_data", {24'b0, rx_data}, 32'h01);
        check("sr_stop_pulses", n_stop - s0, 0);

        // reset during the 4th data bit of a write, then a clean write
        bus_start();
        write_byte(8'h84, addressed(8'h84), ack);
        check("rs_addr_ack", {31'b0, ack}, 1);
        for (int i = 0; i < 3; i++) bus_bit(1'b1, s);
        m_sda = 1'b1; qw();
        m_scl = 1'b1; qw();
        rst_n = 1'b0;
        m_quiet = 1'b1;
        @(negedge clk);
        check("rs_sda_oe", {31'b0, sda_oe}, 0);
        check("rs_busy", {31'b0, busy}, 0);
        check("rs_rx_data", {24'b0, rx_data}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        qw();
        m_scl = 1'b0; qw();
        r0 = n_rx; s0 = n_stop;
        bus_start();
        write_byte(8'h84, addressed(8'h84), ack);
        check("rs2_addr_ack", {31'b0, ack}, 1);
        rx_exp.push_back(8'h5A);
        write_byte(8'h5A, 1'b0, ack);
        check("rs2_data_ack", {31'b0, ack}, 1);
        bus_stop(); qw();
        check("rs2_rx_data", {24'b0, rx_data}, 32'h5A);
        check("rs2_rx_pulses", n_rx - r0, 1);
        check("rs2_stop_pulses", n_stop - s0, 1);

        // STOP after 3 bits of a data byte
        r0 = n_rx; s0 = n_stop;
        bus_start();
        write_byte(8'h84, addressed(8'h84), ack);
        check("ms_addr_ack", {31'b0, ack}, 1);
        bus_bit(1'b1, s);
        bus_bit(1'b0, s);
        bus_bit(1'b1, s);
        bus_stop(); qw();
        check("ms_rx_pulses", n_rx - r0, 0);
        check("ms_stop_pulses", n_stop - s0, 1);
        check("ms_busy", {31'b0, busy}, 0);
        check("ms_rx_pending", rx_exp.size(), 0);

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
